// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - instruction/data memory handshake bundle seen by the stall controller
interface hazard_stall_ctrl_if;
   logic imem_read;
   logic imem_resp;
   logic dmem_read;
   logic dmem_write;
   logic dmem_resp;
   logic imem_hold;

   // Pipeline / memory side: raises requests and responses, observes the fetch hold.
   modport master (
      output imem_read,
      output imem_resp,
      output dmem_read,
      output dmem_write,
      output dmem_resp,
      input  imem_hold
   );

   // Controller side.
   modport slave (
      input  imem_read,
      input  imem_resp,
      input  dmem_read,
      input  dmem_write,
      input  dmem_resp,
      output imem_hold
   );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - pipeline load/bubble/flush control with memory stall watchdog; HAZARD_PERF_EN adds perf counters
module hazard_stall_ctrl #(
   parameter int TIMEOUT = 1024
) (
   input  logic                clk,
   input  logic                rst,
   hazard_stall_ctrl_if.slave  mem,
   input  logic [4:0]          id_rs1,
   input  logic [4:0]          id_rs2,
   input  logic                id_uses_rs1,
   input  logic                id_uses_rs2,
   input  logic [4:0]          ex_rd,
   input  logic                ex_mem_read,
   input  logic                ex_br_taken,
   output logic                load_pc,
   output logic                load_if_id,
   output logic                load_id_ex,
   output logic                load_ex_mem,
   output logic                load_mem_wb,
   output logic                bubble_control,
   output logic                flush_if_id,
   output logic                stall_timeout
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]         perf_stall_cycles,
   output logic [31:0]         perf_bubbles
`endif
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [0:0] RUN     = 1'b0;
   localparam logic [0:0] MEMWAIT = 1'b1;

   logic [0:0]       state;
   logic [0:0]       state_nxt;
   logic             imem_seen;
   logic             dmem_seen;
   logic [CNT_W-1:0] stall_cnt;

   logic             dmem_req;
   logic             ipend;
   logic             dpend;
   logic             stall;
   logic             hazard;
   logic [4:0]       loads;

   // A response already captured during the stall no longer counts as pending.
   assign dmem_req = mem.dmem_read | mem.dmem_write;
   assign ipend    = mem.imem_read & ~mem.imem_resp & ~imem_seen;
   assign dpend    = dmem_req & ~mem.dmem_resp & ~dmem_seen;
   assign stall    = ipend | dpend;

   assign hazard = ex_mem_read & (ex_rd != 5'd0) &
                   ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

   // Stage enables by priority: memory stall freezes all, then branch squash, then load-use bubble.
   always_comb begin
      loads          = 5'b00000;
      bubble_control = 1'b0;
      flush_if_id    = 1'b0;
      if (rst && !stall) begin
         if (ex_br_taken) begin
            loads          = 5'b11111;
            bubble_control = 1'b1;
            flush_if_id    = 1'b1;
         end else if (hazard) begin
            loads          = 5'b00111;
            bubble_control = 1'b1;
         end else begin
            loads          = 5'b11111;
         end
      end
   end

   assign {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = loads;
   assign mem.imem_hold = imem_seen;

   // Next FSM state: sit in MEMWAIT for as long as any memory is pending.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (stall)  state_nxt = MEMWAIT;
         MEMWAIT: if (!stall) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   // FSM, response-seen flags, stall counter and sticky watchdog.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= RUN;
         imem_seen     <= 1'b0;
         dmem_seen     <= 1'b0;
         stall_cnt     <= '0;
         stall_timeout <= 1'b0;
      end else begin
         state <= state_nxt;
         if (stall) begin
            if (mem.imem_read & mem.imem_resp) imem_seen <= 1'b1;
            if (dmem_req & mem.dmem_resp)      dmem_seen <= 1'b1;
            if (stall_cnt != {CNT_W{1'b1}})    stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt == CNT_W'(TIMEOUT - 1)) stall_timeout <= 1'b1;
         end else begin
            imem_seen <= 1'b0;
            dmem_seen <= 1'b0;
            stall_cnt <= '0;
         end
      end
   end

`ifdef HAZARD_PERF_EN
   // Free-running wrap-around counts of stalled cycles and inserted bubbles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_stall_cycles <= 32'd0;
         perf_bubbles      <= 32'd0;
      end else begin
         if (stall)                   perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (!stall && bubble_control) perf_bubbles     <= perf_bubbles + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - self-checking bench for hazard_stall_ctrl with a rule-level reference model
module tb_hazard_stall_ctrl;
   localparam int TIMEOUT = 8;

   logic       clk;
   logic       rst;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_br_taken;
   logic       load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
   logic       bubble_control, flush_if_id, stall_timeout;
`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall_cycles, perf_bubbles;
`endif

   hazard_stall_ctrl_if mem ();

   hazard_stall_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk            (clk),
      .rst            (rst),
      .mem            (mem.slave),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_uses_rs1    (id_uses_rs1),
      .id_uses_rs2    (id_uses_rs2),
      .ex_rd          (ex_rd),
      .ex_mem_read    (ex_mem_read),
      .ex_br_taken    (ex_br_taken),
      .load_pc        (load_pc),
      .load_if_id     (load_if_id),
      .load_id_ex     (load_id_ex),
      .load_ex_mem    (load_ex_mem),
      .load_mem_wb    (load_mem_wb),
      .bubble_control (bubble_control),
      .flush_if_id    (flush_if_id),
      .stall_timeout  (stall_timeout)
`ifdef HAZARD_PERF_EN
      ,
      .perf_stall_cycles (perf_stall_cycles),
      .perf_bubbles      (perf_bubbles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [4:0] loads;
   logic [8:0] obs;
   assign loads = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb};
   assign obs   = {loads, bubble_control, flush_if_id, mem.imem_hold, stall_timeout};

   // Reference model: which memory has already answered during this stall,
   // how many consecutive stalled edges have elapsed, and the watchdog.
   bit          m_iseen, m_dseen, m_to;
   int          m_run;
   int unsigned m_stalls, m_bubbles;

   function automatic bit m_waiting();
      bit iwait;
      bit dwait;
      iwait = mem.imem_read && !mem.imem_resp && !m_iseen;
      dwait = (mem.dmem_read || mem.dmem_write) && !mem.dmem_resp && !m_dseen;
      return iwait || dwait;
   endfunction

   function automatic bit m_load_use();
      bit hit1;
      bit hit2;
      hit1 = id_uses_rs1 && (id_rs1 == ex_rd);
      hit2 = id_uses_rs2 && (id_rs2 == ex_rd);
      return ex_mem_read && (ex_rd != 0) && (hit1 || hit2);
   endfunction

   // Expected {loads[4:0], bubble, flush, imem_hold, stall_timeout}.
   function automatic logic [8:0] m_expect();
      logic [1:0] tail;
      tail = {m_iseen, m_to};
      if (!rst)        return 9'd0;
      if (m_waiting()) return {5'b00000, 2'b00, tail};
      if (ex_br_taken) return {5'b11111, 2'b11, tail};
      if (m_load_use()) return {5'b00111, 2'b10, tail};
      return {5'b11111, 2'b00, tail};
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_iseen   <= 1'b0;
         m_dseen   <= 1'b0;
         m_to      <= 1'b0;
         m_run     <= 0;
         m_stalls  <= 0;
         m_bubbles <= 0;
      end else if (m_waiting()) begin
         if (mem.imem_read && mem.imem_resp) m_iseen <= 1'b1;
         if ((mem.dmem_read || mem.dmem_write) && mem.dmem_resp) m_dseen <= 1'b1;
         if (m_run + 1 == TIMEOUT) m_to <= 1'b1;
         m_run    <= m_run + 1;
         m_stalls <= m_stalls + 1;
      end else begin
         if (ex_br_taken || m_load_use()) m_bubbles <= m_bubbles + 1;
         m_iseen <= 1'b0;
         m_dseen <= 1'b0;
         m_run   <= 0;
      end
   end

   task automatic idle();
      mem.imem_read = 0; mem.imem_resp = 0;
      mem.dmem_read = 0; mem.dmem_write = 0; mem.dmem_resp = 0;
      id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
      ex_rd = 0; ex_mem_read = 0; ex_br_taken = 0;
   endtask

   task automatic randomize_inputs();
      mem.imem_read  = ($urandom_range(0, 3) != 0);
      mem.imem_resp  = 1'($urandom_range(0, 1));
      mem.dmem_read  = ($urandom_range(0, 3) == 0);
      mem.dmem_write = ($urandom_range(0, 5) == 0);
      mem.dmem_resp  = 1'($urandom_range(0, 1));
      id_rs1         = 5'($urandom_range(0, 3));
      id_rs2         = 5'($urandom_range(0, 3));
      id_uses_rs1    = 1'($urandom_range(0, 1));
      id_uses_rs2    = 1'($urandom_range(0, 1));
      ex_rd          = 5'($urandom_range(0, 3));
      ex_mem_read    = 1'($urandom_range(0, 1));
      ex_br_taken    = ($urandom_range(0, 6) == 0);
   endtask

   task automatic test_reset();
      rst = 0;
      for (int i = 0; i < 4; i++) begin
         randomize_inputs();
         #1;
         n_checks++;
         if (obs !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_outputs cycle %0d: got %b need %b", i, obs, 9'd0);
         end
         @(negedge clk);
      end
      idle();
      mem.imem_read = 1; mem.imem_resp = 1;
      #1 rst = 1;
      #1;
      n_checks++;
      if (loads !== 5'b11111) begin
         n_fail++;
         $display("FAIL reset_release_loads: got %b need %b", loads, 5'b11111);
      end
      n_checks++;
      if ({mem.imem_hold, stall_timeout} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_state: hold/timeout got %b need 00", {mem.imem_hold, stall_timeout});
      end
      @(negedge clk);
      idle();
   endtask

   task automatic test_load_use();
      idle();
      ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
      id_rs1 = 3; id_uses_rs1 = 1;
      #1;
      n_checks++;
      if (obs[8:2] !== 7'b0011110) begin
         n_fail++;
         $display("FAIL load_use_bubble: got %b need %b", obs[8:2], 7'b0011110);
      end
      @(negedge clk);
      ex_mem_read = 0; ex_rd = 0;
      #1;
      n_checks++;
      if (obs[8:2] !== 7'b1111100) begin
         n_fail++;
         $display("FAIL load_use_one_bubble: got %b need %b", obs[8:2], 7'b1111100);
      end
      @(negedge clk);
      ex_mem_read = 1; ex_rd = 0; id_rs2 = 0; id_uses_rs2 = 1;
      #1;
      n_checks++;
      if (obs[8:2] !== 7'b1111100) begin
         n_fail++;
         $display("FAIL load_use_x0: got %b need %b", obs[8:2], 7'b1111100);
      end
      @(negedge clk);
      idle();
   endtask

   task automatic test_split_resp();
      logic [4:0] exp_loads [1:6] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b11111, 5'b11111};
      logic       exp_hold  [1:6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int c = 1; c <= 6; c++) begin
         idle();
         if (c <= 5) begin
            mem.imem_read = 1; mem.dmem_read = 1;
         end
         mem.imem_resp = (c == 2);
         mem.dmem_resp = (c == 5);
         #1;
         n_checks++;
         if (loads !== exp_loads[c] || mem.imem_hold !== exp_hold[c]) begin
            n_fail++;
            $display("FAIL split_resp cycle %0d: loads/hold got %b/%b need %b/%b",
                     c, loads, mem.imem_hold, exp_loads[c], exp_hold[c]);
         end
         @(negedge clk);
      end
      idle();
   endtask

   task automatic test_branch_stall();
      for (int c = 1; c <= 4; c++) begin
         idle();
         ex_br_taken = 1;
         ex_mem_read = 1; ex_rd = 7; id_rs1 = 7; id_uses_rs1 = 1;
         mem.dmem_read = 1;
         mem.dmem_resp = (c == 4);
         #1;
         n_checks++;
         if (c < 4 && obs[8:2] !== 7'b0000000) begin
            n_fail++;
            $display("FAIL branch_stall_frozen cycle %0d: got %b need %b", c, obs[8:2], 7'b0000000);
         end else if (c == 4 && obs[8:2] !== 7'b1111111) begin
            n_fail++;
            $display("FAIL branch_release: got %b need %b", obs[8:2], 7'b1111111);
         end
         @(negedge clk);
      end
      idle();
   endtask

   task automatic test_watchdog();
      for (int c = 1; c <= 10; c++) begin
         idle();
         mem.dmem_read = 1;
         #1;
         n_checks++;
         if (stall_timeout !== ((c - 1) >= TIMEOUT)) begin
            n_fail++;
            $display("FAIL watchdog cycle %0d: got %b need %b", c, stall_timeout, ((c - 1) >= TIMEOUT));
         end
         @(negedge clk);
      end
      mem.dmem_resp = 1;
      #1;
      n_checks++;
      if ({loads, stall_timeout} !== 6'b111111) begin
         n_fail++;
         $display("FAIL watchdog_sticky: got %b need %b", {loads, stall_timeout}, 6'b111111);
      end
      @(negedge clk);
      idle();
      mem.dmem_read = 1;
      @(negedge clk);
      #2 rst = 0;
      #1;
      n_checks++;
      if (obs !== 9'd0) begin
         n_fail++;
         $display("FAIL watchdog_async_reset: got %b need %b", obs, 9'd0);
      end
      idle();
      @(negedge clk);
      rst = 1;
   endtask

   task automatic test_random();
      logic [8:0] exp;
      for (int i = 0; i < 400; i++) begin
         randomize_inputs();
         #1;
         exp = m_expect();
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL random cycle %0d: got %b need %b", i, obs, exp);
         end
         @(negedge clk);
      end
      idle();
   endtask

`ifdef HAZARD_PERF_EN
   task automatic test_perf();
      rst = 0;
      #1 rst = 1;
      for (int c = 1; c <= 8; c++) begin
         idle();
         if (c <= 4) mem.dmem_read = 1;
         mem.dmem_resp = (c == 4);
         if (c == 5 || c == 7) begin
            ex_mem_read = 1; ex_rd = 9; id_rs2 = 9; id_uses_rs2 = 1;
         end
         #1;
         @(negedge clk);
      end
      #1;
      n_checks++;
      if (perf_stall_cycles !== 32'd3 || perf_bubbles !== 32'd2) begin
         n_fail++;
         $display("FAIL perf_counters: stalls/bubbles got %0d/%0d need 3/2", perf_stall_cycles, perf_bubbles);
      end
      n_checks++;
      if (perf_stall_cycles !== m_stalls || perf_bubbles !== m_bubbles) begin
         n_fail++;
         $display("FAIL perf_model: stalls/bubbles got %0d/%0d need %0d/%0d",
                  perf_stall_cycles, perf_bubbles, m_stalls, m_bubbles);
      end
   endtask
`endif

   initial begin
      rst = 0;
      idle();
      @(negedge clk);
      test_reset();
      test_load_use();
      test_split_resp();
      test_branch_stall();
      test_watchdog();
      test_random();
`ifdef HAZARD_PERF_EN
      test_perf();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline control block that drives the stage-register side of the pipeline: the `load` enables of PC, IF/ID, ID/EX, EX/MEM and MEM/WB, plus `bubble_control` into ID/EX.
- Freezes the whole pipeline while instruction or data memory has an outstanding request.
- Inserts one bubble on a load-use hazard and squashes on a taken branch resolved in EX.
- Tracks memory responses that arrive while the other memory is still pending, and raises a sticky watchdog flag when a memory stall runs too long.

Parameters:
- TIMEOUT, 1024: stall cycles after which `stall_timeout` sets. Legal range 2..65535.
- CNT_W, $clog2(TIMEOUT+1): width of the stall counter. Derived; not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_read  in  1  fetch request to instruction memory is active.
- imem_resp  in  1  instruction memory response for the current request.
- dmem_read  in  1  MEM-stage load request.
- dmem_write  in  1  MEM-stage store request.
- dmem_resp  in  1  data memory response.
- id_rs1  in  5  source register 1 of the instruction in ID.
- id_rs2  in  5  source register 2 of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  instruction in EX is a load.
- ex_br_taken  in  1  EX resolved a taken branch or jump.
- load_pc  out  1  PC register load enable.
- load_if_id  out  1  IF/ID load enable.
- load_id_ex  out  1  ID/EX load enable.
- load_ex_mem  out  1  EX/MEM load enable.
- load_mem_wb  out  1  MEM/WB load enable.
- bubble_control  out  1  ID/EX captures a bubble (control word zeroed) on this load.
- flush_if_id  out  1  IF/ID captures a NOP on this load.
- imem_hold  out  1  fetch serves the instruction word already captured, not live rdata.
- stall_timeout  out  1  sticky watchdog error.

Behaviour:
- State: FSM {RUN, MEMWAIT}, sticky flags `imem_seen` and `dmem_seen`, counter `stall_cnt[CNT_W-1:0]`, `stall_timeout` register.
- Reset (rst=0, async):
  - FSM=RUN; flags, counter and `stall_timeout` = 0.
  - While rst=0, every output is 0, including all load enables.
- Pending terms:
  - `ipend = imem_read & ~imem_resp & ~imem_seen`
  - `dpend = (dmem_read|dmem_write) & ~dmem_resp & ~dmem_seen`
  - `stall = ipend | dpend`
- Outputs are combinational from inputs plus registered state; there is zero-cycle latency from input to output.
- Priority within a cycle: `stall` > `ex_br_taken` > load-use hazard.
- stall=1:
  - All five loads = 0; `bubble_control` = 0; `flush_if_id` = 0.
  - Next FSM = MEMWAIT.
- stall=0, ex_br_taken=1:
  - All loads = 1; `flush_if_id` = 1; `bubble_control` = 1.
- stall=0, branch not taken, hazard=1:
  - hazard = `ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd))`.
  - `load_pc` = 0 and `load_if_id` = 0.
  - `load_id_ex`, `load_ex_mem`, `load_mem_wb` = 1; `bubble_control` = 1.
  - Exactly one bubble per hazard: the next cycle EX holds the bubble, so `ex_mem_read` = 0.
- stall=0 otherwise: all loads = 1; `bubble_control` = 0; `flush_if_id` = 0.
- Sticky flags:
  - In any cycle with stall=1, `imem_seen` sets if `imem_read & imem_resp`, and `dmem_seen` sets if `(dmem_read|dmem_write) & dmem_resp`.
  - Both flags clear on the first clock edge where stall=0.
  - `imem_hold = imem_seen`.
- FSM transitions:
  - RUN → MEMWAIT when stall=1.
  - MEMWAIT → RUN when stall=0. That releasing cycle already drives loads per the priority rules.
  - Branch and hazard terms are evaluated only in the releasing cycle, because EX/ID are frozen and stable during the stall.
- Counter:
  - `stall_cnt` increments, saturating, on each edge with stall=1.
  - `stall_cnt` clears on an edge with stall=0.
  - `stall_timeout` sets on an edge where stall=1 and `stall_cnt == TIMEOUT-1`. It stays set until reset.
- Simultaneous responses: both `imem_resp` and `dmem_resp` arriving in the same stalled cycle gives stall=0 in that cycle, and the pipeline advances that cycle.
- Reset asserted mid-stall: FSM, flags, counter and `stall_timeout` clear immediately; outputs go to 0.

Optional Feature:
- Macro: `HAZARD_PERF_EN`.
- Defined:
  - Adds outputs `perf_stall_cycles[31:0]` and `perf_bubbles[31:0]`.
  - `perf_stall_cycles` increments on each edge with stall=1.
  - `perf_bubbles` increments on each edge with stall=0 and `bubble_control`=1.
  - Both wrap at 2^32 and reset to 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: rst=0 with random inputs → all outputs 0. Release rst with imem_read=1, imem_resp=1 → all loads=1 in the same cycle.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 → load_pc=load_if_id=0, bubble_control=1 for exactly 1 cycle. Repeat with ex_rd=0 → no bubble.
- Split responses: imem_read=dmem_read=1, imem_resp at cycle 2, dmem_resp at cycle 5 → loads=0 during cycles 1-4, imem_hold=1 during cycles 3-5, all loads=1 at cycle 5, imem_hold=0 at cycle 6.
- Branch during stall: ex_br_taken=1 held through a 3-cycle dmem stall → flush_if_id=0 while stalled; flush_if_id=bubble_control=1 only in the releasing cycle. Branch and hazard together → branch response only.
- Watchdog: TIMEOUT=8, dmem_read=1 with no resp → stall_timeout rises after 8 stalled edges and stays 1 after dmem_resp. Asserting rst mid-stall clears it asynchronously.
- HAZARD_PERF_EN: 3 stall cycles plus 2 load-use bubbles → perf_stall_cycles=3, perf_bubbles=2.
